// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan controller.
package mux_scan_pkg;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam int N_CH_DEF  = 7;
  localparam int SEL_W_DEF = 3;
  localparam int DWELL_DEF = 4;

  // Dwell counter width; a 1-cycle dwell still needs a 1-bit counter.
  function automatic int dwell_cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Counts cycles spent on one channel; last flags the dwell-final cycle.
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DWELL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW = dwell_cnt_w(DWELL);
  localparam logic [CW-1:0] LAST_V = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign last = (cnt == LAST_V);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select over all channels, samples y at each dwell end and
// publishes one snapshot per scan over a valid/ready output.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  output logic [SEL_W-1:0] sel,
  input  logic             y,
  output logic [N_CH-1:0]  snap,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic             busy,
  output logic             overrun,
  output state_t           state_dbg
);

  // Handshake: snap is transferred on any edge with snap_valid && snap_ready;
  // snap and snap_valid hold while snap_ready is low, and a new load on the
  // transfer edge replaces the data and keeps snap_valid high.

  state_t          state, state_nxt;
  logic            last;
  logic            capture, sel_last, scan_end, load;
  logic [N_CH-1:0] shadow, candidate;

  assign capture  = (state == SCAN) && last;
  assign sel_last = (sel == SEL_W'(N_CH - 1));
  assign scan_end = capture && sel_last;
  assign load     = scan_end && (!snap_valid || snap_ready);
  assign busy     = (state == SCAN);
  assign state_dbg = state;

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .en    (state == SCAN),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: if (scan_end && !cont) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final channel goes straight into the snapshot, bypassing shadow.
  always_comb begin
    candidate = shadow;
    candidate[N_CH-1] = y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      shadow <= '0;
    end else if (state == IDLE) begin
      sel <= '0;
    end else if (capture) begin
      shadow[sel] <= y;
      sel         <= sel_last ? '0 : sel + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      snap_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        snap       <= candidate;
        snap_valid <= 1'b1;
      end else if (snap_valid && snap_ready) begin
        snap_valid <= 1'b0;
      end
      if (state == IDLE && start)      overrun <= 1'b0;
      else if (scan_end && !load)      overrun <= 1'b1;
    end
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Scan controller that sits around the 7:1 data multiplexer in the selector datapath. It drives the mux select through every channel in order and holds each channel for a programmable dwell time. At the end of each dwell it samples the mux output. It assembles one N_CH-bit snapshot per scan and hands it downstream over a valid/ready handshake.

Parameters:
N_CH, 7, number of mux channels scanned (2 ≤ N_CH ≤ 2**SEL_W)
SEL_W, 3, select width; matches mux sel port
DWELL, 4, cycles each channel is held; sample taken on the last one (DWELL ≥ 1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a scan; honoured only in IDLE
cont  in  1  continuous mode; sampled at the end of each scan
sel  out  SEL_W  mux select, registered
y  in  1  mux output, sampled on the dwell-final edge
snap  out  N_CH  snapshot; snap[k] = y sampled while sel==k
snap_valid  out  1  snap holds unconsumed data
snap_ready  in  1  downstream accepts snap
busy  out  1  high in SCAN
overrun  out  1  sticky; a scan completed while the previous snap was unconsumed

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, dwell count=0, shadow=0, snap=0, snap_valid=0, busy=0, overrun=0.
- IDLE: sel=0, busy=0.
  - Edge with start=1: go to SCAN, sel=0, dwell=0, busy=1, overrun cleared.
- SCAN, every edge:
  - If dwell < DWELL-1: dwell++.
  - Else (dwell==DWELL-1): shadow[sel] <= y.
    - If sel < N_CH-1: sel++, dwell=0.
    - If sel == N_CH-1: end of scan, see below.
- End of scan (same edge as the final capture):
  - Candidate word = shadow with bit N_CH-1 replaced by the current y.
  - If snap_valid==0 or snap_ready==1: snap <= candidate, snap_valid=1.
  - Otherwise: snap unchanged, overrun=1 (sticky).
  - Then if cont=1: stay in SCAN, sel=0, dwell=0.
  - If cont=0: go to IDLE, sel=0, busy=0.
- Latency: the first snapshot is loaded exactly N_CH*DWELL edges after the edge that accepted start (28 at defaults). In cont mode a new snapshot follows every N_CH*DWELL edges with no gap.
- Handshake: when snap_valid && snap_ready at an edge with no load, snap_valid clears. Load and consume on the same edge: the load wins, so snap_valid stays 1 with the new data. snap is stable while snap_valid=1 and snap_ready=0.
- start while busy: ignored, no effect on overrun.
- DWELL=1: a capture on every SCAN edge; sel advances every cycle.
- sel never exceeds N_CH-1. Channels N_CH..2**SEL_W-1 are never selected.
- Reset mid-scan: everything returns to reset values immediately. The partial shadow is discarded and no snap_valid is asserted.

Decomposition:
- Package mux_scan_pkg:
  - state typedef enum {IDLE, SCAN}
  - default constants N_CH_DEF=7, SEL_W_DEF=3, DWELL_DEF=4
  - function clog2-based width for the dwell counter
- One sub-module, dwell_timer: parameter DWELL; inputs clk, rst_n, clear, en; output last (dwell==DWELL-1).
- The top level holds the FSM, sel counter, shadow register and output handshake.

Test Plan:
- Bench model y = PAT[sel] with PAT=7'b1010011; pulse start, cont=0, snap_ready=0 -> snap_valid rises 28 edges later, snap=7'b1010011, busy falls on the same edge, sel=0 afterwards.
- Check sel sequence in the same run -> sel holds each value 0..6 for exactly 4 cycles, sampling only on the dwell-final edge. Toggle y mid-dwell -> the toggle has no effect on snap.
- cont=1, PAT changed to 7'b0111100 after the first snap, snap_ready held 1 -> back-to-back snapshots every 28 edges; second snap=7'b0111100; overrun stays 0.
- cont=1, snap_ready=0 -> second scan completion sets overrun=1 and snap keeps its first value. Then raise snap_ready for one cycle -> snap_valid clears. A new start from IDLE clears overrun.
- snap_ready=1 on the exact edge a scan completes, with snap_valid=1 -> snap_valid stays 1 with the new data; no overrun.
- Assert rst_n=0 at cycle 10 of a scan -> all outputs 0 immediately, no snap_valid. start pulsed during SCAN -> ignored. DWELL=1 build -> snapshot after 7 edges.
